mul_bias: RTL and testbench
===========================

Name: mul_bias

Overview:
- Pipelined signed multiply-add for one neuron term: `mul = node * wegt + bias`.
- Sits in the low-level compute layer of the fully-connected datapath, feeding accumulators and activation logic.
- Two-stage registered pipeline with a valid flag alongside the data; no back-pressure.

Parameters:
- DATA_W, 8: width of node, wegt and bias (two's-complement signed).
- OUT_W, 16: width of the result (two's-complement signed).
- SAT_EN, 1: 1 = saturate the result to the OUT_W range; 0 = wrap (keep the low OUT_W bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  node/wegt/bias are valid this cycle.
- node  input  DATA_W  signed activation input.
- wegt  input  DATA_W  signed weight.
- bias  input  DATA_W  signed bias.
- out_valid  output  1  mul holds a newly computed result.
- mul  output  OUT_W  signed result.

Behaviour:
- Reset (asynchronous, active-high):
  - All pipeline registers clear: mul = 0, out_valid = 0.
  - Reset asserted mid-operation discards in-flight data immediately.
  - Normal operation resumes on the first rising clk edge after rst deasserts.
- Stage 1 (clock edge where in_valid = 1):
  - Register the full-precision signed product node * wegt, width 2*DATA_W.
  - Register bias sign-extended to 2*DATA_W+1 bits.
  - Register valid1 = in_valid.
- Stage 2 (every edge):
  - sum = sign-extended product + sign-extended bias, width 2*DATA_W+1.
  - Register the final result into mul and valid1 into out_valid.
- Latency: inputs sampled at edge N produce mul/out_valid at edge N+2. Throughput is one operation per cycle; back-to-back in_valid is fully supported.
- Input capture when in_valid = 0:
  - Stage-1 data registers hold their previous contents; valid1 = 0.
  - mul holds its last computed value; out_valid = 0 for that slot.
- Width and overflow:
  - All arithmetic is signed. Bias is sign-extended, never zero-extended.
  - With defaults the full range fits in 16 bits without overflow: max 16384 + 127 = 16511, min -16256 - 128 = -16384.
  - If OUT_W < 2*DATA_W+1 and SAT_EN = 1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If OUT_W < 2*DATA_W+1 and SAT_EN = 0: truncate to the low OUT_W bits.
  - If OUT_W > 2*DATA_W+1: sign-extend the result.
- Corner case: node = wegt = -128 gives product +16384; this must not be treated as negative.
- No combinational path from any input to any output.

Test Plan:
- Reset, then node = 0, wegt = 0, bias = 0, in_valid = 1 -> two cycles later mul = 0, out_valid = 1. During reset: mul = 0, out_valid = 0.
- Sign combinations, bias = 0, one per cycle:
  - (-50, -50) -> 2500
  - (50, -50) -> -2500
  - (-50, 50) -> -2500
  - Each result appears 2 cycles after its input, back-to-back.
- node = 50, wegt = 50, bias = -101 -> mul = 2399.
- Extremes:
  - (-128, -128, 127) -> 16511
  - (-128, 127, -128) -> -16384
  - (127, 127, 127) -> 16256
- Valid gating:
  - Pulse in_valid for one cycle with (3, 4, 5) -> out_valid high for exactly one cycle, mul = 17; mul then holds 17 while out_valid = 0.
  - Assert rst mid-stream with two ops in flight -> mul = 0 and out_valid = 0 immediately, with no stale outputs after release.
- Parameter variant OUT_W = 12, SAT_EN = 1, inputs (-128, -128, 127) -> mul = 2047. Same case with SAT_EN = 0 -> low 12 bits of 16511, i.e. 127.

Source files
------------

// File: rtl/mul_bias.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_bias                                                        |
// | Brief    : Two-stage pipelined signed multiply-add, mul = node*wegt + bias |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mul_bias #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int SAT_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] node,
  input  logic [DATA_W-1:0] wegt,
  input  logic [DATA_W-1:0] bias,
  output logic              out_valid,
  output logic [OUT_W-1:0]  mul
);

  localparam int c_prod_w = 2 * DATA_W;
  localparam int c_sum_w  = c_prod_w + 1;

  logic signed [c_prod_w-1:0] w_prod;
  logic signed [c_prod_w-1:0] r_prod;
  logic signed [c_sum_w-1:0]  r_bias;
  logic signed [c_sum_w-1:0]  w_sum;
  logic        [OUT_W-1:0]    w_res;
  logic                       r_valid1;

  // Operands are widened as signed before multiplying, so -128 * -128 stays positive.
  assign w_prod = $signed(node) * $signed(wegt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod   <= '0;
      r_bias   <= '0;
      r_valid1 <= 1'b0;
    end else begin
      r_valid1 <= in_valid;
      if (in_valid) begin
        r_prod <= w_prod;
        r_bias <= {{(DATA_W + 1){bias[DATA_W-1]}}, bias};
      end
    end
  end

  assign w_sum = {r_prod[c_prod_w-1], r_prod} + r_bias;

  generate
    if (OUT_W < c_sum_w && SAT_EN != 0) begin : g_sat
      // Bits at and above the output sign must all agree, otherwise the sum is out of range.
      logic [c_sum_w-OUT_W:0] w_top;
      logic                   w_ovf;
      assign w_top = w_sum[c_sum_w-1:OUT_W-1];
      assign w_ovf = ~((&w_top) | ~(|w_top));
      assign w_res = !w_ovf ? w_sum[OUT_W-1:0] :
                     (w_sum[c_sum_w-1] ? {1'b1, {(OUT_W - 1){1'b0}}}
                                       : {1'b0, {(OUT_W - 1){1'b1}}});
    end else begin : g_pass
      // Signed size cast: truncates when narrowing, sign-extends when widening.
      assign w_res = OUT_W'(w_sum);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      mul       <= '0;
    end else begin
      out_valid <= r_valid1;
      mul       <= w_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_bias.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mul_bias                                                     |
// | Brief    : Scoreboard bench for mul_bias (default, 12-bit sat, 12-bit wrap)|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mul_bias;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  node = '0;
  logic [7:0]  wegt = '0;
  logic [7:0]  bias = '0;
  logic        ov16, ovs, ovw;
  logic [15:0] m16;
  logic [11:0] ms, mw;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {
    int          due;
    logic [15:0] e16;
    logic [11:0] es;
    logic [11:0] ew;
  } exp_t;
  exp_t q[$];

  mul_bias #(.DATA_W(8), .OUT_W(16), .SAT_EN(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .node(node), .wegt(wegt),
    .bias(bias), .out_valid(ov16), .mul(m16));

  mul_bias #(.DATA_W(8), .OUT_W(12), .SAT_EN(1)) u_sat12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .node(node), .wegt(wegt),
    .bias(bias), .out_valid(ovs), .mul(ms));

  mul_bias #(.DATA_W(8), .OUT_W(12), .SAT_EN(0)) u_wrap12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .node(node), .wegt(wegt),
    .bias(bias), .out_valid(ovw), .mul(mw));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model computes with plain integers, then clamps or truncates.
  task automatic drive(input int n, input int w, input int b);
    int   full;
    exp_t e;
    full  = n * w + b;
    e.due = cyc + 2;
    e.e16 = full[15:0];
    e.ew  = full[11:0];
    if (full > 2047)       e.es = 12'h7FF;
    else if (full < -2048) e.es = 12'h800;
    else                   e.es = full[11:0];
    q.push_back(e);
    node     = n[7:0];
    wegt     = w[7:0];
    bias     = b[7:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic due;
      exp_t e;
      due = (q.size() > 0) && (q[0].due == cyc);
      check("valid16", ov16, due);
      check("valid_sat12", ovs, due);
      check("valid_wrap12", ovw, due);
      if (due) begin
        e = q.pop_front();
        check("mul16", m16, e.e16);
        check("mul_sat12", ms, e.es);
        check("mul_wrap12", mw, e.ew);
      end
    end
  end

  initial begin
    logic [7:0] r0, r1, r2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mul16", m16, 0);
    check("rst_valid16", ov16, 0);
    check("rst_mul12", ms, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    drive(0, 0, 0);
    idle(2);

    drive(-50, -50, 0);
    drive(50, -50, 0);
    drive(-50, 50, 0);
    drive(50, 50, -101);
    drive(-128, -128, 127);
    drive(-128, 127, -128);
    drive(127, 127, 127);
    idle(3);

    drive(3, 4, 5);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_valid", ov16, 0);
    check("hold_mul16", m16, 17);
    check("hold_mul_sat12", ms, 17);
    idle(2);

    // Two ops in flight: first reaching the output, second in stage 1.
    drive(1, 2, 3);
    drive(4, 5, 6);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_mul16", m16, 0);
    check("midrst_valid16", ov16, 0);
    check("midrst_mul_wrap12", mw, 0);
    check("midrst_valid_sat12", ovs, 0);
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    check("post_rst_mul16", m16, 0);
    check("post_rst_valid16", ov16, 0);

    for (int i = 0; i < 10; i++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      drive(int'($signed(r0)), int'($signed(r1)), int'($signed(r2)));
    end
    idle(4);
    check("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
